bnn_xnor_sequencer: RTL and testbench

//  Upstream feeder for the BNN accumulation counter. Accepts one binary activation vector
//  and one weight vector, preloads the counter with a bias, then scans the vectors LSB-first,
//  one bit per cycle. For every XNOR match it issues a single-cycle count-up strobe, so the

---
 rtl/bnn_pkg.sv | 14 +
 rtl/bnn_bit_scanner.sv | 52 +++++
 rtl/bnn_xnor_sequencer.sv | 105 ++++++++++
 tb/tb_bnn_xnor_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and default sizes for the BNN XNOR sequencer.
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int VEC_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/bnn_bit_scanner.sv
// Holds the captured activation/weight/mask vectors and the scan index;
// presents the bits selected by the index plus a flag on the final bit.
module bnn_bit_scanner
    import bnn_pkg::*;
#(
    parameter int VEC_W = VEC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic             advance,
    input  logic [VEC_W-1:0] act_vec,
    input  logic [VEC_W-1:0] wgt_vec,
    input  logic [VEC_W-1:0] mask_vec,
    output logic             act_bit,
    output logic             wgt_bit,
    output logic             mask_bit,
    output logic             last
);

    localparam int IDX_W = $clog2(VEC_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_W - 1);

    logic [VEC_W-1:0] act_q;
    logic [VEC_W-1:0] wgt_q;
    logic [VEC_W-1:0] mask_q;
    logic [IDX_W-1:0] idx;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q  <= '0;
            wgt_q  <= '0;
            mask_q <= '0;
            idx    <= '0;
        end else if (capture) begin
            act_q  <= act_vec;
            wgt_q  <= wgt_vec;
            mask_q <= mask_vec;
            idx    <= '0;
        end else if (advance) begin
            // Return to zero after the final bit so the index never wraps mid-scan.
            idx <= last ? '0 : idx + 1'b1;
        end
    end

    assign act_bit  = act_q[idx];
    assign wgt_bit  = wgt_q[idx];
    assign mask_bit = mask_q[idx];
    assign last     = (idx == LAST_IDX);

endmodule

// File: rtl/bnn_xnor_sequencer.sv
// Feeds a BNN accumulation counter: preloads a bias, then strobes count_up per XNOR match.
// Optional BNN_MASK_EN adds mask_vec, which prunes individual bits from counting.
module bnn_xnor_sequencer
    import bnn_pkg::*;
#(
    parameter int VEC_W = VEC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] act_vec,
    input  logic [VEC_W-1:0] wgt_vec,
`ifdef BNN_MASK_EN
    input  logic [VEC_W-1:0] mask_vec,
`endif
    input  logic [CNT_W-1:0] bias,
    input  logic             stall,
    output logic             load,
    output logic [CNT_W-1:0] load_data,
    output logic             count_up,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] bias_q;
    logic [VEC_W-1:0] mask_in;
    logic             transfer;
    logic             advance;
    logic             act_bit;
    logic             wgt_bit;
    logic             mask_bit;
    logic             last;
    logic             count_next;

`ifdef BNN_MASK_EN
    assign mask_in = mask_vec;
`else
    assign mask_in = '1;
`endif

    assign transfer = in_valid && in_ready;
    assign advance  = (state == SCAN) && !stall;

    bnn_bit_scanner #(
        .VEC_W (VEC_W)
    ) u_scanner (
        .clk      (clk),
        .reset    (reset),
        .capture  (transfer),
        .advance  (advance),
        .act_vec  (act_vec),
        .wgt_vec  (wgt_vec),
        .mask_vec (mask_in),
        .act_bit  (act_bit),
        .wgt_bit  (wgt_bit),
        .mask_bit (mask_bit),
        .last     (last)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        count_next = 1'b0;
        case (state)
            IDLE: if (transfer) state_next = LOAD;
            LOAD: state_next = SCAN;
            SCAN: begin
                if (advance) begin
                    count_next = ~(act_bit ^ wgt_bit) & mask_bit;
                    if (last) state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes trail the state by one cycle, which gives the load/count/done latencies.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bias_q    <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            load      <= 1'b0;
            load_data <= '0;
            count_up  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == IDLE);
            busy     <= (state_next != IDLE);
            load     <= (state == LOAD);
            count_up <= count_next;
            done     <= (state == DONE);
            if (transfer)      bias_q    <= bias;
            if (state == LOAD) load_data <= bias_q;
        end
    end

endmodule

// File: tb/tb_bnn_xnor_sequencer.sv
// Self-checking bench for bnn_xnor_sequencer; exercises mask pruning when BNN_MASK_EN is defined.
module tb_bnn_xnor_sequencer;

    localparam int VEC_W = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [VEC_W-1:0] act_vec = '0;
    logic [VEC_W-1:0] wgt_vec = '0;
    logic [VEC_W-1:0] mask_vec = '1;
    logic [CNT_W-1:0] bias = '0;
    logic             stall = 1'b0;
    logic             load;
    logic [CNT_W-1:0] load_data;
    logic             count_up;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fails  = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    always #5 clk = ~clk;

    bnn_xnor_sequencer #(
        .VEC_W (VEC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act_vec   (act_vec),
        .wgt_vec   (wgt_vec),
`ifdef BNN_MASK_EN
        .mask_vec  (mask_vec),
`endif
        .bias      (bias),
        .stall     (stall),
        .load      (load),
        .load_data (load_data),
        .count_up  (count_up),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream counter: load has priority over count_up.
    always @(posedge clk) begin
        if (load) model_cnt <= load_data;
        else if (count_up) model_cnt <= model_cnt + 1'b1;
    end

    // One full transaction. Expected strobe pattern comes straight from the bit rules:
    // bit i counts when act[i]==wgt[i] and mask[i]==1; stall_len idle cycles are
    // inserted before scanning bit stall_at.
    task automatic run_txn(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] w,
                           input logic [VEC_W-1:0] m, input logic [CNT_W-1:0] b,
                           input int stall_at, input int stall_len, input bit hold_valid);
        logic exp_cu[$];
        logic stl[$];
        logic [VEC_W-1:0] match;
        logic [CNT_W-1:0] exp_total;
        int budget;
        match = ~(a ^ w);
`ifdef BNN_MASK_EN
        match = match & m;
`endif
        exp_total = b + CNT_W'($countones(match));
        for (int i = 0; i < VEC_W; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    exp_cu.push_back(1'b0);
                    stl.push_back(1'b1);
                end
            end
            exp_cu.push_back(match[i]);
            stl.push_back(1'b0);
        end

        budget = 0;
        while (!in_ready && budget < 20) begin
            tick();
            budget++;
        end
        check("ready_before_transfer", 32'(in_ready), 32'd1);

        act_vec  = a;
        wgt_vec  = w;
        mask_vec = m;
        bias     = b;
        in_valid = 1'b1;
        tick();
        if (!hold_valid) in_valid = 1'b0;
        act_vec = ~a;
        wgt_vec = a;
        bias    = ~b;
        check("busy_after_transfer", 32'(busy), 32'd1);
        check("ready_low_after_transfer", 32'(in_ready), 32'd0);
        check("no_load_yet", 32'(load), 32'd0);

        tick();
        check("load_strobe", 32'(load), 32'd1);
        check("load_data", 32'(load_data), 32'(b));
        check("no_count_with_load", 32'(count_up), 32'd0);

        for (int k = 0; k < exp_cu.size(); k++) begin
            stall = stl[k];
            tick();
            check($sformatf("count_up_step%0d", k), 32'(count_up), 32'(exp_cu[k]));
            check("load_low_in_scan", 32'(load), 32'd0);
            check("done_low_in_scan", 32'(done), 32'd0);
            if (hold_valid) check("ready_low_while_busy", 32'(in_ready), 32'd0);
        end
        stall = 1'b0;

        tick();
        in_valid = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("ready_after_done", 32'(in_ready), 32'd1);
        check("busy_low_after_done", 32'(busy), 32'd0);
        check("count_low_at_done", 32'(count_up), 32'd0);
        check("counter_total", 32'(model_cnt), 32'(exp_total));
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        logic [VEC_W-1:0] ra;
        logic [VEC_W-1:0] rw;
        logic [CNT_W-1:0] rb;

        // Reset state.
        reset = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_load", 32'(load), 32'd0);
        check("rst_count_up", 32'(count_up), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_load_data", 32'(load_data), 32'd0);
        reset = 1'b0;
        tick();

        // All bits match, bias 0.
        run_txn(8'hFF, 8'hFF, 8'hFF, 8'd0, -1, 0, 1'b0);
        // No bits match, bias 40.
        run_txn(8'hAA, 8'h55, 8'hFF, 8'd40, -1, 0, 1'b0);
        // Upper nibble matches; in_valid held high while busy.
        run_txn(8'h0F, 8'h00, 8'hFF, 8'd7, -1, 0, 1'b1);
        // Three-cycle stall at idx 2.
        run_txn(8'hFF, 8'hFF, 8'hFF, 8'd0, 2, 3, 1'b0);

        // Reset mid-scan at idx 5.
        act_vec  = 8'hFF;
        wgt_vec  = 8'hFF;
        bias     = 8'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) tick();
        check("pre_reset_count_up", 32'(count_up), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_count_up", 32'(count_up), 32'd0);
        check("midreset_load", 32'(load), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        tick();
        check("post_reset_idle_count", 32'(count_up), 32'd0);
        run_txn(8'h3C, 8'h0F, 8'hFF, 8'd100, -1, 0, 1'b0);

`ifdef BNN_MASK_EN
        // Mask prunes the lower nibble.
        run_txn(8'hFF, 8'hFF, 8'hF0, 8'd20, -1, 0, 1'b0);
`endif

        // Randomized transactions with a random stall placement.
        for (int t = 0; t < 8; t++) begin
            ra = VEC_W'($urandom);
            rw = VEC_W'($urandom);
            rb = CNT_W'($urandom);
            run_txn(ra, rw, VEC_W'($urandom), rb, int'($urandom_range(0, VEC_W)),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
